prn_free_list: RTL and testbench
================================

// Module: prn_free_list
// PURPOSE
//  Physical-register free list and allocation arbiter feeding the rename stage.
//  Supplies up to 2 free PRNs per cycle (free_PRN[1:0]) to the RAT, shared by threads 0/1.
//  Generates stall_0/stall_1 on PRN exhaustion or per-thread quota. Reclaims up to 2 PRNs
//  per cycle from retirement and from the ROB squash walk after a mispredict.
//  Sits between the ROB/retire logic and the RAT/PRF dispatch path.
// PARAMETERS
//  NUM_PR      64  physical registers; PRN NUM_PR-1 is the reserved zero/unmapped PRN, never listed
//  THREAD_CAP  40  max PRNs one thread may hold (allocated, not yet freed)
// PORTS
//  clock          in   1           single clock, rising edge
//  reset_n        in   1           asynchronous, active-low reset
//  alloc_req      in   2           slot i wants a dest PRN (valid, dest!=`ZERO_REG, not flushed); stall-independent
//  alloc_tid      in   2           thread id of slot i
//  free_valid     in   2           slot i returns a PRN this cycle (retire or squash)
//  free_prn       in   2x`PR_BITS  PRN returned by slot i
//  free_tid       in   2           thread owning free_prn[i]
//  free_PRN       out  2x`PR_BITS  PRN to rename slot i (to RAT)
//  stall_0        out  1           slot 0 cannot be renamed this cycle
//  stall_1        out  1           slot 1 cannot be renamed this cycle
//  free_count     out  `PR_BITS+1  PRNs currently in list (registered)
//  thread_held    out  2x`PR_BITS+1 PRNs held per thread (registered)
// BEHAVIOUR
//  - Storage: circular list[NUM_PR-1]; head/tail carry wrap bit; count register.
//  - Reset (async, reset_n=0): list[i]=i for i=0..NUM_PR-2, head=0, tail=0, count=NUM_PR-1,
//    thread_held=0. All outputs at reset: stall_0=stall_1=0 when no req, free_PRN[0]=0,
//    free_PRN[1]=1, free_count=NUM_PR-1. Reset mid-operation discards all state; no drain.
//  - Allocation (combinational from registered state, same cycle):
//    g0 = req0 & (count>=1) & (held[t0]+1 <= THREAD_CAP).
//    g1 = req1 & !stall_0 & (count >= g0+1) & (held[t1]+g0*(t0==t1)+1 <= THREAD_CAP).
//    stall_0 = req0 & !g0; stall_1 = stall_0 | (req1 & !g1)  (in-order dispatch).
//    free_PRN[0]=list[head]; free_PRN[1]=list[head+g0] (slot1 takes head when slot0 allocates none).
//    head += g0+g1 at clock edge.
//  - Free: push valid frees in slot order, slot0 then slot1, at tail; tail += n_free.
//    free_prn==NUM_PR-1 is dropped (no push, no held decrement).
//    Freed PRNs are allocatable the next cycle; no same-cycle bypass.
//  - count_next = count - n_alloc + n_free.
//    held[t]_next = held[t] + allocs(t) - frees(t); all 2x2 combinations in one cycle.
//  - Boundaries:
//    count==0 -> both stall.
//    count==1 with two reqs -> slot0 granted, slot1 stalls.
//    Alloc and free same cycle at count==0 -> stall this cycle, PRN visible next cycle.
//    Pointer wrap at NUM_PR-1 slots: index arithmetic mod NUM_PR-1.
//    Free pushing count above NUM_PR-1, or held[t] underflow -> protocol error: assertion fires;
//    RTL saturates count/held and drops the push.
//  - Mispredict: no special state. The ROB returns squashed dest PRNs via free ports; the RAT
//    restores from the RRAT. Thread-quota stall is independent per thread.
// STRUCTURE
//  - Shared package: PR_FREE typedef {valid, prn[`PR_BITS], tid}; NUM_PR/THREAD_CAP defaults
//    tied to `PR_SIZE; ZERO_PRN = `PR_SIZE-1.
//  - One sub-module: prn_ring_2w2r (2-push/2-pop circular buffer with count);
//    quota and stall logic live in the top.
// TESTING
//  1 Reset, req=2'b11 both t0 -> free_PRN={1,0}, no stall; next cycle free_count=61, held[0]=2.
//  2 Drain to count=1, req=2'b11 -> stall_0=0, stall_1=1, slot0 gets last PRN; next cycle count=0.
//  3 held[1]=39, req both t1 -> slot0 granted, stall_1=1; same req with slot0 t0 -> both granted.
//  4 count=0, free_valid=2'b11 {5,9} with alloc req -> stall; next cycle free_PRN={9,5}, count=2.
//  5 free_prn=63 (NUM_PR-1) -> ignored, count/held unchanged; free at full -> assertion, no push.
//  6 Assert reset_n mid-run with head/tail wrapped -> outputs return to reset values
//    asynchronously, list reinitialised.

Source files
------------

// File: rtl/prn_free_list_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prn_free_list_pkg                                            |
// | Description : Shared types and sizes for the physical-register free list.  |
// |               PR_SIZE physical registers; the last PRN is the reserved     |
// |               zero/unmapped register and is never placed on the list.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package prn_free_list_pkg;

    localparam int PR_SIZE        = 64;
    localparam int PR_BITS        = $clog2(PR_SIZE);
    localparam int ZERO_PRN       = PR_SIZE - 1;
    localparam int THREAD_CAP_DEF = 40;

    // One returned register as seen on a free slot after filtering out the
    // reserved PRN.
    typedef struct packed {
        logic               valid;
        logic [PR_BITS-1:0] prn;
        logic               tid;
    } PR_FREE;

endpackage
`default_nettype wire

// File: rtl/prn_free_list_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prn_free_list_if                                             |
// | Description : Allocation / reclaim bundle between rename, ROB and the      |
// |               physical-register free list.                                 |
// |   alloc_req[1:0]    slot wants a destination PRN                           |
// |   alloc_tid[1:0]    thread of each allocating slot                         |
// |   free_valid[1:0]   slot returns a PRN (retire or squash walk)             |
// |   free_prn[1:0]     PRN returned per slot                                  |
// |   free_tid[1:0]     thread owning each returned PRN                        |
// |   free_PRN[1:0]     PRN handed to each rename slot                         |
// |   stall_0/stall_1   slot cannot be renamed this cycle                      |
// |   free_count        PRNs currently on the list                             |
// |   thread_held[1:0]  PRNs held per thread                                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface prn_free_list_if;
    import prn_free_list_pkg::*;

    logic [1:0]               alloc_req;
    logic [1:0]               alloc_tid;
    logic [1:0]               free_valid;
    logic [1:0][PR_BITS-1:0]  free_prn;
    logic [1:0]               free_tid;
    logic [1:0][PR_BITS-1:0]  free_PRN;
    logic                     stall_0;
    logic                     stall_1;
    logic [PR_BITS:0]         free_count;
    logic [1:0][PR_BITS:0]    thread_held;

    // Rename / ROB side.
    modport master (
        output alloc_req, alloc_tid, free_valid, free_prn, free_tid,
        input  free_PRN, stall_0, stall_1, free_count, thread_held
    );

    // Free-list side.
    modport slave (
        input  alloc_req, alloc_tid, free_valid, free_prn, free_tid,
        output free_PRN, stall_0, stall_1, free_count, thread_held
    );

endinterface
`default_nettype wire

// File: rtl/prn_ring_2w2r.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prn_ring_2w2r                                                |
// | Description : Circular buffer with up to two pushes and two pops per       |
// |               cycle and an explicit occupancy count. Resets full, holding  |
// |               entry i = i.                                                 |
// |   clock, reset_n  clock and asynchronous active-low reset                  |
// |   i_push_cnt      number of entries pushed (0..2), data packed from [0]    |
// |   i_push_data     push data, slot 0 first                                  |
// |   i_pop_cnt       number of entries popped (0..2)                          |
// |   o_head_data     entries at head and head+1                               |
// |   o_count         current occupancy                                        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module prn_ring_2w2r #(
    parameter int DEPTH = 63,
    parameter int DW    = 6,
    parameter int CW    = 7
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [1:0]          i_push_cnt,
    input  logic [1:0][DW-1:0]  i_push_data,
    input  logic [1:0]          i_pop_cnt,
    output logic [1:0][DW-1:0]  o_head_data,
    output logic [CW-1:0]       o_count
);

    localparam int c_iw = $clog2(DEPTH);

    // Index plus a wrap bit that toggles every lap; head == tail with
    // differing wrap bits means full.
    typedef struct packed {
        logic            wrap;
        logic [c_iw-1:0] idx;
    } ptr_t;

    // Advance a pointer by 0..2 entries, modulo DEPTH (not a power of two).
    function automatic ptr_t ptr_add(input ptr_t p, input logic [1:0] inc);
        logic [c_iw:0] sum;
        ptr_add = p;
        sum     = {1'b0, p.idx} + {{(c_iw-1){1'b0}}, inc};
        if (sum >= (c_iw+1)'(DEPTH)) begin
            ptr_add.idx  = c_iw'(sum - (c_iw+1)'(DEPTH));
            ptr_add.wrap = ~p.wrap;
        end else begin
            ptr_add.idx  = sum[c_iw-1:0];
        end
    endfunction

    logic [DW-1:0] r_list [DEPTH];
    ptr_t          r_head;
    ptr_t          r_tail;
    logic [CW-1:0] r_count;
    ptr_t          w_head_p1;
    ptr_t          w_tail_p1;

    assign w_head_p1      = ptr_add(r_head, 2'd1);
    assign w_tail_p1      = ptr_add(r_tail, 2'd1);
    assign o_head_data[0] = r_list[r_head.idx];
    assign o_head_data[1] = r_list[w_head_p1.idx];
    assign o_count        = r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_list[i] <= DW'(i);
            end
            r_head  <= '{wrap: 1'b0, idx: '0};
            r_tail  <= '{wrap: 1'b1, idx: '0};
            r_count <= CW'(DEPTH);
        end else begin
            if (i_push_cnt != 2'd0) begin
                r_list[r_tail.idx] <= i_push_data[0];
            end
            if (i_push_cnt == 2'd2) begin
                r_list[w_tail_p1.idx] <= i_push_data[1];
            end
            r_head  <= ptr_add(r_head, i_pop_cnt);
            r_tail  <= ptr_add(r_tail, i_push_cnt);
            r_count <= r_count - CW'(i_pop_cnt) + CW'(i_push_cnt);
        end
    end

endmodule
`default_nettype wire

// File: rtl/prn_free_list.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prn_free_list                                                |
// | Description : Physical-register free list and two-slot allocation arbiter  |
// |               for the rename stage, shared by threads 0/1 with a per-      |
// |               thread quota. Reclaims up to two PRNs per cycle from retire  |
// |               and from the ROB squash walk.                                |
// |   clock, reset_n  clock and asynchronous active-low reset                  |
// |   fl (slave)      allocation requests, reclaim slots, granted PRNs,        |
// |                   stalls, free_count and per-thread held counts            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module prn_free_list
    import prn_free_list_pkg::*;
#(
    parameter int NUM_PR     = PR_SIZE,
    parameter int THREAD_CAP = THREAD_CAP_DEF
) (
    input  logic            clock,
    input  logic            reset_n,
    prn_free_list_if.slave  fl
);

    localparam int                 c_depth    = NUM_PR - 1;
    localparam int                 c_cw       = PR_BITS + 1;
    localparam logic [PR_BITS-1:0] c_zero_prn = PR_BITS'(NUM_PR - 1);

    typedef logic [c_cw-1:0] cnt_t;

    cnt_t                     r_held [2];
    cnt_t                     w_count;
    logic [1:0][PR_BITS-1:0]  w_head_data;
    cnt_t                     w_held_a0;
    cnt_t                     w_held_a1;
    logic                     w_g0;
    logic                     w_g1;
    logic                     w_stall_0;
    logic                     w_stall_1;
    logic                     w_same_a;
    logic [1:0]               w_pop_cnt;
    PR_FREE [1:0]             w_free;
    cnt_t                     w_room;
    logic                     w_acc0;
    logic                     w_acc1;
    logic                     w_same_f;
    logic [1:0]               w_push_cnt;
    logic [1:0][PR_BITS-1:0]  w_push_data;
    logic [1:0]               w_alloc_n [2];
    logic [1:0]               w_rel_n [2];

    // Reclaim slots with the reserved PRN filtered out.
    for (genvar i = 0; i < 2; i++) begin : g_free_dec
        assign w_free[i] = '{valid: fl.free_valid[i] && (fl.free_prn[i] != c_zero_prn),
                             prn:   fl.free_prn[i],
                             tid:   fl.free_tid[i]};
    end

    // Allocation: in-order dispatch, so slot 1 can never get ahead of a
    // stalled slot 0. Slot 1's quota check includes slot 0's grant when both
    // slots belong to the same thread.
    always_comb begin
        w_held_a0 = r_held[fl.alloc_tid[0]];
        w_held_a1 = r_held[fl.alloc_tid[1]];
        w_g0      = fl.alloc_req[0] && (w_count != '0) && (w_held_a0 < cnt_t'(THREAD_CAP));
        w_stall_0 = fl.alloc_req[0] && !w_g0;
        w_same_a  = w_g0 && (fl.alloc_tid[0] == fl.alloc_tid[1]);
        w_g1      = fl.alloc_req[1] && !w_stall_0 && (w_count > cnt_t'(w_g0))
                    && ((w_held_a1 + cnt_t'(w_same_a)) < cnt_t'(THREAD_CAP));
        w_stall_1 = w_stall_0 || (fl.alloc_req[1] && !w_g1);
        w_pop_cnt = {1'b0, w_g0} + {1'b0, w_g1};
    end

    // Reclaim: a push is dropped if it would overfill the list or drive the
    // owning thread's held count below zero. Frees never bypass into this
    // cycle's allocation; they become visible at the head next cycle.
    always_comb begin
        w_room         = cnt_t'(c_depth) - w_count + cnt_t'(w_pop_cnt);
        w_acc0         = w_free[0].valid && (r_held[w_free[0].tid] != '0) && (w_room != '0);
        w_same_f       = w_acc0 && (w_free[0].tid == w_free[1].tid);
        w_acc1         = w_free[1].valid && (r_held[w_free[1].tid] > cnt_t'(w_same_f))
                         && (w_room > cnt_t'(w_acc0));
        w_push_cnt     = {1'b0, w_acc0} + {1'b0, w_acc1};
        w_push_data[0] = w_acc0 ? w_free[0].prn : w_free[1].prn;
        w_push_data[1] = w_free[1].prn;
    end

    always_comb begin
        for (int t = 0; t < 2; t++) begin
            w_alloc_n[t] = {1'b0, w_g0 && (fl.alloc_tid[0] == 1'(t))}
                         + {1'b0, w_g1 && (fl.alloc_tid[1] == 1'(t))};
            w_rel_n[t]   = {1'b0, w_acc0 && (w_free[0].tid == 1'(t))}
                         + {1'b0, w_acc1 && (w_free[1].tid == 1'(t))};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_held <= '{default: '0};
        end else begin
            for (int t = 0; t < 2; t++) begin
                r_held[t] <= r_held[t] + cnt_t'(w_alloc_n[t]) - cnt_t'(w_rel_n[t]);
            end
        end
    end

    prn_ring_2w2r #(
        .DEPTH (c_depth),
        .DW    (PR_BITS),
        .CW    (c_cw)
    ) u_ring (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_push_cnt  (w_push_cnt),
        .i_push_data (w_push_data),
        .i_pop_cnt   (w_pop_cnt),
        .o_head_data (w_head_data),
        .o_count     (w_count)
    );

    // Slot 1 takes the head only when it is the sole requester; otherwise it
    // sees head+1 (its value is irrelevant whenever slot 0 stalls).
    assign fl.free_PRN[0]    = w_head_data[0];
    assign fl.free_PRN[1]    = (!fl.alloc_req[0] && fl.alloc_req[1]) ? w_head_data[0]
                                                                      : w_head_data[1];
    assign fl.stall_0        = w_stall_0;
    assign fl.stall_1        = w_stall_1;
    assign fl.free_count     = w_count;
    assign fl.thread_held[0] = r_held[0];
    assign fl.thread_held[1] = r_held[1];

`ifdef PRN_FREE_LIST_PROTOCOL_CHECKS
    always_ff @(posedge clock) begin
        if (reset_n) begin
            assert (!(w_free[0].valid && !w_acc0))
                else $error("prn_free_list: slot0 free of PRN %0d rejected (overflow or held underflow)", w_free[0].prn);
            assert (!(w_free[1].valid && !w_acc1))
                else $error("prn_free_list: slot1 free of PRN %0d rejected (overflow or held underflow)", w_free[1].prn);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_prn_free_list.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_prn_free_list                                             |
// | Description : Directed self-checking bench for prn_free_list: a table of   |
// |               single-cycle vectors from reset, then hand-written sequences |
// |               for quota, exhaustion, free-at-empty and async reset.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_prn_free_list;
    import prn_free_list_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    prn_free_list_if bus ();

    prn_free_list #(
        .NUM_PR     (PR_SIZE),
        .THREAD_CAP (40)
    ) dut (
        .clock   (clk),
        .reset_n (reset_n),
        .fl      (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int q[$];          // expected free-list order, head first
    int m_held [2];

    typedef struct {
        logic [1:0] req;
        logic [1:0] atid;
        logic [1:0] fv;
        int         fp0;
        int         fp1;
        logic [1:0] ftid;
        logic       s0;
        logic       s1;
        int         p0;
        int         p1;
        int         cnt;
        int         h0;
        int         h1;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] atid, input logic [1:0] fv,
                         input int fp0, input int fp1, input logic [1:0] ftid);
        bus.alloc_req   = req;
        bus.alloc_tid   = atid;
        bus.free_valid  = fv;
        bus.free_prn[0] = PR_BITS'(fp0);
        bus.free_prn[1] = PR_BITS'(fp1);
        bus.free_tid    = ftid;
    endtask

    task automatic check_regs(input string tag, input int cnt, input int h0, input int h1);
        chk({tag, ".free_count"}, 32'(bus.free_count), cnt);
        chk({tag, ".held0"}, 32'(bus.thread_held[0]), h0);
        chk({tag, ".held1"}, 32'(bus.thread_held[1]), h1);
    endtask

    // One allocation-only cycle checked against the queue model.
    task automatic alloc_cycle(input logic [1:0] req, input logic [1:0] tid,
                               input logic exp_s0, input logic exp_s1, input string tag);
        logic g0;
        logic g1;
        @(negedge clk);
        drive(req, tid, 2'b00, 0, 0, 2'b00);
        #1;
        chk({tag, ".stall_0"}, 32'(bus.stall_0), 32'(exp_s0));
        chk({tag, ".stall_1"}, 32'(bus.stall_1), 32'(exp_s1));
        g0 = req[0] && !exp_s0;
        g1 = req[1] && !exp_s1;
        if (g0) chk({tag, ".prn0"}, 32'(bus.free_PRN[0]), q[0]);
        if (g1) chk({tag, ".prn1"}, 32'(bus.free_PRN[1]), g0 ? q[1] : q[0]);
        @(posedge clk);
        #1;
        if (g0) begin void'(q.pop_front()); m_held[tid[0]]++; end
        if (g1) begin void'(q.pop_front()); m_held[tid[1]]++; end
        check_regs(tag, q.size(), m_held[0], m_held[1]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            req    atid   fv     fp0 fp1 ftid   s0    s1    p0 p1 cnt h0 h1
        tbl[0] = '{2'b00, 2'b00, 2'b00, 0,  0,  2'b00, 1'b0, 1'b0, 0, 1, 63, 0, 0};
        tbl[1] = '{2'b11, 2'b00, 2'b00, 0,  0,  2'b00, 1'b0, 1'b0, 0, 1, 61, 2, 0};
        tbl[2] = '{2'b10, 2'b10, 2'b00, 0,  0,  2'b00, 1'b0, 1'b0, 2, 2, 60, 2, 1};
        tbl[3] = '{2'b01, 2'b01, 2'b11, 0,  1,  2'b00, 1'b0, 1'b0, 3, 4, 61, 0, 2};
        tbl[4] = '{2'b00, 2'b00, 2'b11, 63, 2,  2'b11, 1'b0, 1'b0, 4, 5, 62, 0, 1};
        tbl[5] = '{2'b00, 2'b00, 2'b01, 7,  0,  2'b00, 1'b0, 1'b0, 4, 5, 62, 0, 1};
        tbl[6] = '{2'b00, 2'b00, 2'b11, 3,  10, 2'b11, 1'b0, 1'b0, 4, 5, 63, 0, 0};
        tbl[7] = '{2'b00, 2'b00, 2'b11, 5,  6,  2'b10, 1'b0, 1'b0, 4, 5, 63, 0, 0};
        tbl[8] = '{2'b11, 2'b10, 2'b00, 0,  0,  2'b00, 1'b0, 1'b0, 4, 5, 61, 1, 1};

        drive(2'b00, 2'b00, 2'b00, 0, 0, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(tbl[i].req, tbl[i].atid, tbl[i].fv, tbl[i].fp0, tbl[i].fp1, tbl[i].ftid);
            #1;
            chk($sformatf("v%0d.stall_0", i), 32'(bus.stall_0), 32'(tbl[i].s0));
            chk($sformatf("v%0d.stall_1", i), 32'(bus.stall_1), 32'(tbl[i].s1));
            chk($sformatf("v%0d.prn0", i), 32'(bus.free_PRN[0]), tbl[i].p0);
            chk($sformatf("v%0d.prn1", i), 32'(bus.free_PRN[1]), tbl[i].p1);
            @(posedge clk);
            #1;
            check_regs($sformatf("v%0d", i), tbl[i].cnt, tbl[i].h0, tbl[i].h1);
        end

        // List contents after the table: PRNs 6..62 then the recycled 0..3.
        q.delete();
        for (int i = 6; i < 63; i++) q.push_back(i);
        for (int i = 0; i < 4; i++) q.push_back(i);
        m_held[0] = 1;
        m_held[1] = 1;

        // Thread 1 up to 39 held.
        for (int i = 0; i < 19; i++) alloc_cycle(2'b11, 2'b11, 1'b0, 1'b0, "fill_t1");

        // Quota: both slots t1 -> slot 1 stalls; slot 0 moved to t0 -> both granted.
        @(negedge clk);
        drive(2'b11, 2'b11, 2'b00, 0, 0, 2'b00);
        #1;
        chk("quota_t1t1.stall_0", 32'(bus.stall_0), 0);
        chk("quota_t1t1.stall_1", 32'(bus.stall_1), 1);
        chk("quota_t1t1.prn0", 32'(bus.free_PRN[0]), q[0]);
        bus.alloc_tid = 2'b10;
        #1;
        chk("quota_t0t1.stall_0", 32'(bus.stall_0), 0);
        chk("quota_t0t1.stall_1", 32'(bus.stall_1), 0);
        chk("quota_t0t1.prn0", 32'(bus.free_PRN[0]), q[0]);
        chk("quota_t0t1.prn1", 32'(bus.free_PRN[1]), q[1]);
        @(posedge clk);
        #1;
        void'(q.pop_front());
        void'(q.pop_front());
        m_held[0]++;
        m_held[1]++;
        check_regs("quota_t0t1", q.size(), m_held[0], m_held[1]);

        // Thread 1 at cap: slot 0 from t1 stalls both; t0 in slot 0 still proceeds.
        alloc_cycle(2'b11, 2'b01, 1'b1, 1'b1, "cap_slot0_t1");
        alloc_cycle(2'b11, 2'b10, 1'b0, 1'b1, "cap_slot1_t1");

        // Drain to a single entry, then two requests against it.
        alloc_cycle(2'b01, 2'b00, 1'b0, 1'b0, "drain_single");
        for (int i = 0; i < 9; i++) alloc_cycle(2'b11, 2'b00, 1'b0, 1'b0, "drain_pair");
        chk("drain.count_is_1", 32'(q.size()), 1);
        alloc_cycle(2'b11, 2'b00, 1'b0, 1'b1, "last_prn");
        alloc_cycle(2'b11, 2'b00, 1'b1, 1'b1, "empty");

        // Free while empty: stall now, PRNs visible next cycle in push order.
        @(negedge clk);
        drive(2'b11, 2'b00, 2'b11, 5, 9, 2'b00);
        #1;
        chk("free_at_empty.stall_0", 32'(bus.stall_0), 1);
        chk("free_at_empty.stall_1", 32'(bus.stall_1), 1);
        @(posedge clk);
        #1;
        q.push_back(5);
        q.push_back(9);
        m_held[0] -= 2;
        check_regs("free_at_empty", 2, m_held[0], m_held[1]);
        @(negedge clk);
        drive(2'b00, 2'b00, 2'b00, 0, 0, 2'b00);
        #1;
        chk("after_free.prn0", 32'(bus.free_PRN[0]), 5);
        chk("after_free.prn1", 32'(bus.free_PRN[1]), 9);
        alloc_cycle(2'b11, 2'b00, 1'b0, 1'b0, "realloc_freed");

        // Asynchronous reset mid-cycle with both pointers wrapped.
        @(negedge clk);
        drive(2'b11, 2'b00, 2'b00, 0, 0, 2'b00);
        #1;
        chk("pre_reset.stall_0", 32'(bus.stall_0), 1);
        #1;
        reset_n = 1'b0;
        #1;
        check_regs("async_reset", 63, 0, 0);
        chk("async_reset.stall_0", 32'(bus.stall_0), 0);
        chk("async_reset.stall_1", 32'(bus.stall_1), 0);
        chk("async_reset.prn0", 32'(bus.free_PRN[0]), 0);
        chk("async_reset.prn1", 32'(bus.free_PRN[1]), 1);
        @(posedge clk);
        #1;
        check_regs("held_in_reset", 63, 0, 0);
        @(negedge clk);
        drive(2'b00, 2'b00, 2'b00, 0, 0, 2'b00);
        reset_n = 1'b1;
        q.delete();
        for (int i = 0; i < 63; i++) q.push_back(i);
        m_held[0] = 0;
        m_held[1] = 0;
        alloc_cycle(2'b11, 2'b00, 1'b0, 1'b0, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
